// File: rtl/alu_decoder_seq.sv
// Registered ALU control decoder for the RV32 + CNN MAC pipeline.
// Widened codes cover RV32I, RV32M and MAC; multi-cycle ops are sequenced with a valid/ready handshake.
module alu_decoder_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [6:0]        op,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              illegal_o,
    output logic              busy_o
);

    localparam int MAX_ML  = (MUL_LAT > MAC_LAT) ? MUL_LAT : MAC_LAT;
    localparam int MAX_LAT = (DIV_LAT > MAX_ML) ? DIV_LAT : MAX_ML;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAC = CNT_W'(MAC_LAT - 1);

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_AND  = 4'b0010;
    localparam logic [3:0] C_OR   = 4'b0011;
    localparam logic [3:0] C_XOR  = 4'b0100;
    localparam logic [3:0] C_SLT  = 4'b0101;
    localparam logic [3:0] C_SLTU = 4'b0110;
    localparam logic [3:0] C_MAC  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_MUL  = 4'b1100;
    localparam logic [3:0] C_MULH = 4'b1101;
    localparam logic [3:0] C_DIV  = 4'b1110;
    localparam logic [3:0] C_REM  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        OUT  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             ill_q, ill_d;

    logic [3:0]       dec_code_s;
    logic             dec_ill_s;
    logic [CNT_W-1:0] dec_cnt_s;
    logic             is_mext_s;
    logic             f7_known_s;
    logic             f7_alt_bad_s;
    logic             accept_s;
    logic             unused_op_s;

    // Only op[5] (register vs immediate form) matters to this decoder.
    assign unused_op_s  = ^{op[6], op[4:0]};

    assign is_mext_s    = op[5] && (funct7 == 7'b0000001);
    assign f7_known_s   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) || (funct7 == 7'b0000001);
    assign f7_alt_bad_s = (funct7 == 7'b0100000) && (funct3 != 3'b000) && (funct3 != 3'b101);

    // Field decode: control code, illegal flag and counter preload for the op on the inputs.
    always_comb begin
        dec_code_s = C_ADD;
        dec_ill_s  = 1'b0;
        dec_cnt_s  = CNT_ONE;
        case (ALUOp)
            2'b00: dec_code_s = C_ADD;
            2'b01: dec_code_s = C_SUB;
            2'b11: begin
                dec_code_s = C_MAC;
                dec_cnt_s  = CNT_MAC;
            end
            2'b10: begin
                if (is_mext_s) begin
                    case (funct3)
                        3'b000: begin
                            dec_code_s = C_MUL;
                            dec_cnt_s  = CNT_MUL;
                        end
                        3'b001, 3'b010, 3'b011: begin
                            dec_code_s = C_MULH;
                            dec_cnt_s  = CNT_MUL;
                        end
                        3'b100, 3'b101: begin
                            dec_code_s = C_DIV;
                            dec_cnt_s  = CNT_DIV;
                        end
                        default: begin
                            dec_code_s = C_REM;
                            dec_cnt_s  = CNT_DIV;
                        end
                    endcase
                end else if (op[5] && (!f7_known_s || f7_alt_bad_s)) begin
                    dec_code_s = C_ADD;
                    dec_ill_s  = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  dec_code_s = (op[5] && funct7[5]) ? C_SUB : C_ADD;
                        3'b001:  dec_code_s = C_SLL;
                        3'b010:  dec_code_s = C_SLT;
                        3'b011:  dec_code_s = C_SLTU;
                        3'b100:  dec_code_s = C_XOR;
                        3'b101:  dec_code_s = funct7[5] ? C_SRA : C_SRL;
                        3'b110:  dec_code_s = C_OR;
                        default: dec_code_s = C_AND;
                    endcase
                end
            end
            default: dec_code_s = C_ADD;
        endcase
    end

    assign ready_o  = (state_q == IDLE) || ((state_q == OUT) && ready_i);
    assign accept_s = valid_i && ready_o && !flush_i;

    // Next-state logic; flush outranks accept, and an accept in OUT chains the next op without a bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = CNT_W'(0);
        end else if (accept_s) begin
            ctrl_d  = dec_code_s;
            ill_d   = dec_ill_s;
            cnt_d   = dec_cnt_s;
            state_d = (dec_cnt_s == CNT_ONE) ? OUT : BUSY;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = OUT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = OUT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_W'(0);
            ctrl_q  <= 4'b0000;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
        end
    end

    assign valid_o    = (state_q == OUT);
    assign busy_o     = (state_q == BUSY);
    assign alu_ctrl_o = CTRL_W'(ctrl_q);
    assign illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_decoder_seq.sv
// Directed bench for alu_decoder_seq: vector table for decode/latency plus handshake, flush and reset sequences.
module tb_alu_decoder_seq;

    logic       clk;
    logic       rst;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] op;
    logic       flush_i;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] alu_ctrl_o;
    logic       illegal_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] aluop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [6:0] opc;
        logic [3:0] code;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;

    alu_decoder_seq #(
        .CTRL_W (4),
        .MUL_LAT(2),
        .DIV_LAT(32),
        .MAC_LAT(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUOp     (ALUOp),
        .funct3    (funct3),
        .funct7    (funct7),
        .op        (op),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .alu_ctrl_o(alu_ctrl_o),
        .illegal_o (illegal_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [6:0] o, input logic [3:0] c, input logic il, input int l);
        vec_t v;
        v.aluop = a; v.f3 = f3; v.f7 = f7; v.opc = o; v.code = c; v.ill = il; v.lat = l;
        return v;
    endfunction

    task automatic drive(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] o);
        ALUOp = a; funct3 = f3; funct7 = f7; op = o;
    endtask

    // Called just after the accept edge; returns at the falling edge of the first valid_o cycle.
    task automatic expect_seq(input int lat, input logic [3:0] code, input logic ill, input string nm);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk({nm, "_valid"}, 32'(valid_o), 32'(k == lat));
            if (k < lat) begin
                chk({nm, "_busy"}, 32'(busy_o), 32'd1);
                chk({nm, "_rdy_busy"}, 32'(ready_o), 32'd0);
                @(posedge clk);
                #1;
            end else begin
                chk({nm, "_busy_out"}, 32'(busy_o), 32'd0);
                chk({nm, "_code"}, 32'(alu_ctrl_o), 32'(code));
                chk({nm, "_ill"}, 32'(illegal_o), 32'(ill));
            end
        end
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        drive(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].opc);
        valid_i = 1'b1;
        @(negedge clk);
        chk({nm, "_rdy"}, 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        expect_seq(vecs[i].lat, vecs[i].code, vecs[i].ill, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back(mk(2'b10, 3'b000, 7'b0100000, R_OP, 4'b0001, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b000, 7'b0100000, I_OP, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b000, 7'b0000000, R_OP, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b001, 7'b0000000, R_OP, 4'b1000, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b010, 7'b0000000, R_OP, 4'b0101, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b011, 7'b0000000, R_OP, 4'b0110, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b100, 7'b0000000, R_OP, 4'b0100, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b101, 7'b0000000, R_OP, 4'b1001, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b101, 7'b0100000, R_OP, 4'b1010, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b110, 7'b0000000, R_OP, 4'b0011, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b111, 7'b0000000, R_OP, 4'b0010, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b111, 7'b0100000, R_OP, 4'b0000, 1'b1, 1));
        vecs.push_back(mk(2'b10, 3'b001, 7'b0100000, R_OP, 4'b0000, 1'b1, 1));
        vecs.push_back(mk(2'b10, 3'b000, 7'b1111111, R_OP, 4'b0000, 1'b1, 1));
        vecs.push_back(mk(2'b10, 3'b110, 7'b1111111, I_OP, 4'b0011, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b101, 7'b0100000, I_OP, 4'b1010, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b000, 7'b0000001, I_OP, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(2'b00, 3'b111, 7'b0100000, R_OP, 4'b0000, 1'b0, 1));
        vecs.push_back(mk(2'b01, 3'b000, 7'b0000000, R_OP, 4'b0001, 1'b0, 1));
        vecs.push_back(mk(2'b11, 3'b000, 7'b0000000, R_OP, 4'b0111, 1'b0, 3));
        vecs.push_back(mk(2'b10, 3'b000, 7'b0000001, R_OP, 4'b1100, 1'b0, 2));
        vecs.push_back(mk(2'b10, 3'b001, 7'b0000001, R_OP, 4'b1101, 1'b0, 2));
        vecs.push_back(mk(2'b10, 3'b011, 7'b0000001, R_OP, 4'b1101, 1'b0, 2));
        vecs.push_back(mk(2'b10, 3'b101, 7'b0000001, R_OP, 4'b1110, 1'b0, 32));
        vecs.push_back(mk(2'b10, 3'b110, 7'b0000001, R_OP, 4'b1111, 1'b0, 32));
        vecs.push_back(mk(2'b10, 3'b111, 7'b0000001, R_OP, 4'b1111, 1'b0, 32));

        rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        drive(2'b00, 3'b000, 7'b0000000, 7'b0000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_code", 32'(alu_ctrl_o), 32'd0);
        chk("rst_ill", 32'(illegal_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i);
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i), 32'(valid_o), 32'd0);
            @(posedge clk);
            #1;
        end

        // DIV with a competing request held during BUSY
        drive(2'b10, 3'b100, 7'b0000001, R_OP);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        drive(2'b00, 3'b000, 7'b0000000, R_OP);
        expect_seq(32, 4'b1110, 1'b0, "div_hold");
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("div_no_queue_valid", 32'(valid_o), 32'd0);
        chk("div_no_queue_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;

        // MAC held by backpressure, then back-to-back ADD in the release cycle
        ready_i = 1'b0;
        drive(2'b11, 3'b000, 7'b0000000, R_OP);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        expect_seq(3, 4'b0111, 1'b0, "mac");
        @(posedge clk);
        #1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk("mac_hold_valid", 32'(valid_o), 32'd1);
            chk("mac_hold_code", 32'(alu_ctrl_o), 32'h7);
            chk("mac_hold_rdy", 32'(ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        drive(2'b00, 3'b000, 7'b0000000, R_OP);
        valid_i = 1'b1;
        @(negedge clk);
        chk("mac_rel_code", 32'(alu_ctrl_o), 32'h7);
        chk("mac_rel_rdy", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(valid_o), 32'd1);
        chk("b2b_code", 32'(alu_ctrl_o), 32'h0);
        chk("b2b_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_idle", 32'(valid_o), 32'd0);
        @(posedge clk);
        #1;

        // MUL flushed in its first BUSY cycle
        drive(2'b10, 3'b000, 7'b0000001, R_OP);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_busy", 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            chk("flush_valid", 32'(valid_o), 32'd0);
            chk("flush_idle_busy", 32'(busy_o), 32'd0);
            chk("flush_code_kept", 32'(alu_ctrl_o), 32'hC);
            @(posedge clk);
            #1;
        end

        // flush together with valid_i: nothing accepted
        drive(2'b01, 3'b000, 7'b0000000, R_OP);
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_acc_valid", 32'(valid_o), 32'd0);
        chk("flush_acc_code", 32'(alu_ctrl_o), 32'hC);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a DIV
        drive(2'b10, 3'b100, 7'b0000001, R_OP);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_code", 32'(alu_ctrl_o), 32'd0);
        chk("arst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_vec(17);
        @(negedge clk);
        chk("post_rst_idle", 32'(valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_decoder_seq.md
Name: alu_decoder_seq

Overview:
Parametrised, registered successor to the single-cycle ALU decoder in the RV32 pipeline of the CNN accelerator. Decodes ALUOp/funct3/funct7/op into a widened ALU control code covering full RV32I ALU ops, RV32M multiply/divide and the CNN MAC op. Sequences multi-cycle operations with a valid/ready handshake and a busy stall to the hazard unit. Sits between the Decode stage register and the Execute datapath.

Parameters:
CTRL_W, 4, ALU control width; must be >= 4. Codes are zero-extended above bit 3.
MUL_LAT, 2, cycles from accept to valid_o for MUL/MULH group; >= 1.
DIV_LAT, 32, cycles from accept to valid_o for DIV/REM group; >= 1.
MAC_LAT, 3, cycles from accept to valid_o for CNN MAC; >= 1.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
valid_i  in  1  decode fields valid
ready_o  out  1  block can accept this cycle
ALUOp  in  2  main-decoder ALU op class
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
op  in  7  instruction opcode
flush_i  in  1  synchronous pipeline flush
valid_o  out  1  alu_ctrl_o / illegal_o valid
ready_i  in  1  Execute stage accepts
alu_ctrl_o  out  CTRL_W  registered ALU control code
illegal_o  out  1  registered illegal-encoding flag
busy_o  out  1  multi-cycle op in progress (stall request)

Behaviour:
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, MAC 0111, SLL 1000, SRL 1001, SRA 1010, MUL 1100, MULH 1101, DIV 1110, REM 1111. The legacy 3-bit values are unchanged.
- ALUOp 00 -> ADD (1-cycle). ALUOp 01 -> SUB (1-cycle). ALUOp 11 -> MAC (MAC_LAT).
- ALUOp 10, op[5]=1 and funct7=0000001 (M-ext):
  - funct3 000 -> MUL; 001/010/011 -> MULH (MUL_LAT).
  - 100/101 -> DIV; 110/111 -> REM (DIV_LAT).
- ALUOp 10, otherwise, decode by funct3:
  - 000: SUB if {op[5],funct7[5]}=11, else ADD.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
  - 101: SRA if funct7[5], else SRL.
  - 110 OR; 111 AND.
  - All are 1-cycle.
- illegal_o = ALUOp=10 and op[5]=1 and either:
  - funct7 is not in {0000000, 0100000, 0000001}; or
  - funct7=0100000 and funct3 is not in {000, 101}.
  - On illegal, alu_ctrl_o=ADD with 1-cycle latency.
- FSM states: IDLE, BUSY, OUT.
  - ready_o = (state==IDLE) | (state==OUT & ready_i), combinational.
  - Accept = valid_i & ready_o & !flush_i. On accept, register the code and illegal flag and load cnt = LAT-1.
  - If LAT=1: go to OUT. Otherwise go to BUSY.
  - BUSY: decrement cnt each cycle; when cnt reaches 1, next state is OUT. The next state is OUT, not a further decrement.
  - Net effect: valid_o rises exactly LAT cycles after the accept edge.
- OUT: valid_o=1; code and flag are held stable while ready_i=0.
  - On ready_i=1 with no new accept: go to IDLE.
  - On ready_i=1 with a same-cycle accept: back-to-back, go to OUT or BUSY per the new op.
- busy_o = (state==BUSY). valid_o = (state==OUT).
- flush_i=1 forces IDLE on the next edge from any state. It has priority over accept; the in-flight op is dropped. alu_ctrl_o and illegal_o keep their value, but valid_o=0.
- Inputs in BUSY are ignored because ready_o=0.
- Reset (rst=0, async) from any state: state=IDLE, cnt=0, alu_ctrl_o=0, illegal_o=0, valid_o=0, busy_o=0, ready_o=1. Mid-op reset abandons the op with no output.
- cnt width = clog2(max(MUL_LAT,DIV_LAT,MAC_LAT))+1. It never wraps.

Test Plan:
1. Reset then R-type SUB (ALUOp=10, f3=000, f7=0100000, op=0110011), ready_i=1 -> next cycle valid_o=1, alu_ctrl_o=0001, illegal_o=0, busy_o never 1; I-type ADDI with f7[5]=1 (op=0010011) -> 0000.
2. DIV (ALUOp=10, f3=100, f7=0000001, op=0110011), DIV_LAT=32 -> busy_o=1 and ready_o=0 for 31 cycles, valid_o=1 on cycle 32 with 1110; a new valid_i during BUSY is not accepted.
3. MAC (ALUOp=11) with ready_i=0 for 4 cycles after valid_o -> alu_ctrl_o=0111 held 4 cycles; a back-to-back accept of ADD in the release cycle gives valid_o=1 with 0000 on the next cycle, with no bubble.
4. Illegal R-type f7=0100000, f3=111 -> illegal_o=1 and alu_ctrl_o=0000 after 1 cycle; SRA (f3=101, f7=0100000) -> 1010 with illegal_o=0.
5. MUL accepted, flush_i=1 in its first BUSY cycle -> IDLE next edge, valid_o stays 0; a flush in the same cycle as valid_i -> no accept.
6. rst low asynchronously mid-DIV (cycle 10) -> busy_o, valid_o and alu_ctrl_o go to 0 immediately; after release, ready_o=1 and a fresh ADD completes in 1 cycle.
